// File: rtl/rv_lsu_pkg.sv
// Shared definitions for the multicycle RV load/store unit: funct3 encodings,
// error codes and controller states.
package rv_lsu_pkg;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LD  = 3'b011;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;
   localparam logic [2:0] FUNCT3_LWU = 3'b110;
   localparam logic [2:0] FUNCT3_SB  = 3'b000;
   localparam logic [2:0] FUNCT3_SH  = 3'b001;
   localparam logic [2:0] FUNCT3_SW  = 3'b010;
   localparam logic [2:0] FUNCT3_SD  = 3'b011;

   typedef enum logic [1:0] {
      LSU_OK         = 2'd0,
      LSU_MISALIGNED = 2'd1,
      LSU_ILLEGAL    = 2'd2,
      LSU_TIMEOUT    = 2'd3
   } lsu_err_t;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } lsu_state_t;

endpackage

// File: rtl/rv_lsu_multicycle_load_align.sv
// Load return path: moves the addressed lane down to bit 0, truncates to the
// access size and sign- or zero-extends to XLEN. Purely combinational.
module lsu_load_align #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]              rd_data_i,
   input  logic [$clog2(XLEN/8)-1:0]    lane_i,
   input  logic [1:0]                   size_i,
   input  logic                         unsigned_i,
   output logic [XLEN-1:0]              data_o
);
   localparam int IDX_W = $clog2(XLEN);

   logic [XLEN-1:0]  shifted;
   logic [XLEN-1:0]  mask;
   logic [IDX_W-1:0] msb;
   logic             sign;
   int               width;

   always_comb begin
      shifted = rd_data_i >> {lane_i, 3'b000};
      width   = 8 << size_i;
      // A dword size on a 32-bit unit is rejected upstream; clip so indexing stays in range
      if (width > XLEN) width = XLEN;
      mask    = ~({XLEN{1'b1}} << width);
      msb     = IDX_W'(width - 1);
      sign    = ~unsigned_i & shifted[msb];
      data_o  = (shifted & mask) | ({XLEN{sign}} & ~mask);
   end

endmodule

// File: rtl/rv_lsu_multicycle.sv
// Multicycle load/store unit: classifies a core request, runs one bus access
// with variable latency and an optional timeout, and returns a one-cycle response.
module rv_lsu_multicycle
   import rv_lsu_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_is_store,
   input  logic [2:0]          req_funct3,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [XLEN-1:0]     req_wdata,
   output logic                resp_valid,
   output logic [XLEN-1:0]     resp_rdata,
   output logic [1:0]          resp_err,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [XLEN-1:0]     mem_wr_data,
   output logic [XLEN/8-1:0]   mem_wr_strb,
   output logic                mem_rd_ena,
   output logic                mem_wr_ena,
   input  logic                mem_ack,
   input  logic [XLEN-1:0]     mem_rd_data,
   output logic                busy
);
   localparam int BYTES  = XLEN / 8;
   localparam int LANE_W = $clog2(BYTES);
   localparam int CNT_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   lsu_state_t         state_q, state_d;
   lsu_err_t           err_q, err_d, resp_err_q, resp_err_d;
   logic               store_q, store_d, uns_q, uns_d;
   logic               resp_valid_q, resp_valid_d;
   logic [1:0]         size_q, size_d;
   logic [LANE_W-1:0]  lane_q, lane_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic [XLEN-1:0]    wdata_q, wdata_d, rdata_q, rdata_d, resp_rdata_q, resp_rdata_d;
   logic [BYTES-1:0]   strb_q, strb_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [LANE_W-1:0]  req_lane;
   logic [3:0]         req_nb;
   logic [BYTES-1:0]   req_strb_base, req_strb;
   logic [XLEN-1:0]    req_rep;
   logic               req_illegal, req_misaligned;
   logic [XLEN-1:0]    load_data;

   // Request classification and bus-lane formatting, evaluated straight off the request
   always_comb begin
      req_lane = req_addr[LANE_W-1:0];
      req_nb   = 4'd1 << req_funct3[1:0];
      for (int i = 0; i < BYTES; i++) begin
         req_strb_base[i]  = (i < int'(req_nb));
         req_rep[i*8 +: 8] = req_wdata[(i & (int'(req_nb) - 1))*8 +: 8];
      end
      req_strb       = req_strb_base << req_lane;
      req_illegal    = (int'(req_funct3[1:0]) > LANE_W) | (req_is_store & req_funct3[2]);
      req_misaligned = |(req_lane & LANE_W'((1 << req_funct3[1:0]) - 1));
   end

   lsu_load_align #(.XLEN(XLEN)) u_load_align (
      .rd_data_i  (mem_rd_data),
      .lane_i     (lane_q),
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .data_o     (load_data)
   );

   always_comb begin
      state_d      = state_q;
      err_d        = err_q;
      store_d      = store_q;
      uns_d        = uns_q;
      size_d       = size_q;
      lane_d       = lane_q;
      mem_addr_d   = mem_addr_q;
      wdata_d      = wdata_q;
      strb_d       = strb_q;
      rdata_d      = rdata_q;
      cnt_d        = cnt_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = '0;
      resp_err_d   = LSU_OK;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               store_d = req_is_store;
               uns_d   = req_funct3[2];
               size_d  = req_funct3[1:0];
               lane_d  = req_lane;
               rdata_d = '0;
               cnt_d   = '0;
               if (req_illegal) begin
                  err_d   = LSU_ILLEGAL;
                  state_d = S_RESP;
               end else if (req_misaligned) begin
                  err_d   = LSU_MISALIGNED;
                  state_d = S_RESP;
               end else begin
                  err_d      = LSU_OK;
                  state_d    = S_ACCESS;
                  mem_addr_d = {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                  wdata_d    = req_rep;
                  strb_d     = req_is_store ? req_strb : '0;
               end
            end
         end
         S_ACCESS: begin
            cnt_d = cnt_q + 1'b1;
            // An ack on the same edge the count expires still completes the access
            if (mem_ack) begin
               rdata_d = store_q ? '0 : load_data;
               state_d = S_RESP;
            end else if (TIMEOUT_CYCLES != 0 &&
                         ({1'b0, cnt_q} + 1'b1) == (CNT_W+1)'(TIMEOUT_CYCLES)) begin
               err_d   = LSU_TIMEOUT;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            resp_valid_d = 1'b1;
            resp_rdata_d = rdata_q;
            resp_err_d   = err_q;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         err_q        <= LSU_OK;
         store_q      <= 1'b0;
         uns_q        <= 1'b0;
         size_q       <= '0;
         lane_q       <= '0;
         mem_addr_q   <= '0;
         wdata_q      <= '0;
         strb_q       <= '0;
         rdata_q      <= '0;
         cnt_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= LSU_OK;
      end else begin
         state_q      <= state_d;
         err_q        <= err_d;
         store_q      <= store_d;
         uns_q        <= uns_d;
         size_q       <= size_d;
         lane_q       <= lane_d;
         mem_addr_q   <= mem_addr_d;
         wdata_q      <= wdata_d;
         strb_q       <= strb_d;
         rdata_q      <= rdata_d;
         cnt_q        <= cnt_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Enables decode from state so a reset pulls them low without waiting for a clock
   assign req_ready   = (state_q == S_IDLE) & ~rst;
   assign busy        = (state_q != S_IDLE);
   assign mem_rd_ena  = (state_q == S_ACCESS) & ~store_q;
   assign mem_wr_ena  = (state_q == S_ACCESS) &  store_q;
   assign mem_wr_strb = (state_q == S_ACCESS) ? strb_q : '0;
   assign mem_addr    = mem_addr_q;
   assign mem_wr_data = wdata_q;
   assign resp_valid  = resp_valid_q;
   assign resp_rdata  = resp_rdata_q;
   assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_rv_lsu_multicycle.sv
// Bench for rv_lsu_multicycle: a 32-bit unit (timeout 8) and a 64-bit unit,
// directed requests with a response scoreboard checked by per-unit monitors.
module tb_rv_lsu_multicycle;

   typedef struct {
      logic [63:0] rdata;
      logic [1:0]  err;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst32, rst64;
   logic        rv32 = 1'b0, rv64 = 1'b0, ack32 = 1'b0, ack64 = 1'b0;
   logic        st = 1'b0;
   logic [2:0]  f3 = '0;
   logic [31:0] addr = '0;
   logic [63:0] wdata = '0, rdat = '0;
   bit          sel = 1'b0;

   logic        rdy32, rvld32, rd32, wr32, busy32;
   logic [31:0] rdata32, maddr32, wd32;
   logic [1:0]  err32;
   logic [3:0]  strb32;
   logic        rdy64, rvld64, rd64, wr64, busy64;
   logic [63:0] rdata64, wd64;
   logic [31:0] maddr64;
   logic [1:0]  err64;
   logic [7:0]  strb64;

   logic        o_rdy, o_rd, o_wr, o_busy;
   logic [31:0] o_maddr;
   logic [63:0] o_wd;
   logic [7:0]  o_strb;

   int n_vec = 0, n_err = 0, cyc = 0;
   exp_t q32[$], q64[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rv_lsu_multicycle #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(8)) dut32 (
      .clk(clk), .rst(rst32), .req_valid(rv32), .req_ready(rdy32), .req_is_store(st),
      .req_funct3(f3), .req_addr(addr), .req_wdata(wdata[31:0]), .resp_valid(rvld32),
      .resp_rdata(rdata32), .resp_err(err32), .mem_addr(maddr32), .mem_wr_data(wd32),
      .mem_wr_strb(strb32), .mem_rd_ena(rd32), .mem_wr_ena(wr32), .mem_ack(ack32),
      .mem_rd_data(rdat[31:0]), .busy(busy32));

   rv_lsu_multicycle #(.XLEN(64), .ADDR_W(32)) dut64 (
      .clk(clk), .rst(rst64), .req_valid(rv64), .req_ready(rdy64), .req_is_store(st),
      .req_funct3(f3), .req_addr(addr), .req_wdata(wdata), .resp_valid(rvld64),
      .resp_rdata(rdata64), .resp_err(err64), .mem_addr(maddr64), .mem_wr_data(wd64),
      .mem_wr_strb(strb64), .mem_rd_ena(rd64), .mem_wr_ena(wr64), .mem_ack(ack64),
      .mem_rd_data(rdat), .busy(busy64));

   assign o_rdy   = sel ? rdy64   : rdy32;
   assign o_rd    = sel ? rd64    : rd32;
   assign o_wr    = sel ? wr64    : wr32;
   assign o_busy  = sel ? busy64  : busy32;
   assign o_maddr = sel ? maddr64 : maddr32;
   assign o_wd    = sel ? wd64    : {32'h0, wd32};
   assign o_strb  = sel ? strb64  : {4'h0, strb32};

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rvld32 === 1'b1) begin
         if (q32.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL resp32_unexpected: got resp_valid at cycle %0d expected none", cyc);
         end else begin
            e = q32.pop_front();
            chk("resp32_rdata", 64'(rdata32), e.rdata);
            chk("resp32_err", 64'(err32), 64'(e.err));
            chk("resp32_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rvld64 === 1'b1) begin
         if (q64.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL resp64_unexpected: got resp_valid at cycle %0d expected none", cyc);
         end else begin
            e = q64.pop_front();
            chk("resp64_rdata", rdata64, e.rdata);
            chk("resp64_err", 64'(err64), 64'(e.err));
            chk("resp64_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   // waits = bus cycles before the ack cycle; tmo = no ack, expect the enable to drop
   task automatic issue(input bit s64, input bit st_i, input logic [2:0] f3_i,
                        input logic [31:0] a_i, input logic [63:0] wd_i, input logic [63:0] rd_i,
                        input int waits, input bit tmo, input bit bus,
                        input logic [31:0] e_maddr, input logic [63:0] e_wd, input logic [7:0] e_strb,
                        input logic [63:0] e_rdata, input logic [1:0] e_err);
      int   g;
      exp_t e;
      sel = s64;
      @(negedge clk);
      g = 0;
      while (o_rdy !== 1'b1 && g < 50) begin @(negedge clk); g++; end
      chk("req_ready", 64'(o_rdy), 64'd1);
      st = st_i; f3 = f3_i; addr = a_i; wdata = wd_i;
      if (s64) rv64 = 1'b1; else rv32 = 1'b1;
      @(posedge clk); #1;
      rv32 = 1'b0; rv64 = 1'b0;
      e.rdata = e_rdata; e.err = e_err; e.cyc = cyc + (bus ? waits + 2 : 1);
      if (s64) q64.push_back(e); else q32.push_back(e);
      if (!bus) begin
         @(negedge clk);
         chk("no_bus", 64'({o_rd, o_wr}), 64'd0);
      end else begin
         for (int w = 0; w <= waits; w++) begin
            @(negedge clk);
            chk("bus_en", 64'({o_rd, o_wr}), st_i ? 64'd1 : 64'd2);
            if (w == 0) begin
               chk("mem_addr", 64'(o_maddr), 64'(e_maddr));
               chk("mem_wr_strb", 64'(o_strb), 64'(e_strb));
               if (st_i) chk("mem_wr_data", o_wd, e_wd);
            end
            if (w == waits && !tmo) begin
               rdat = rd_i;
               if (s64) ack64 = 1'b1; else ack32 = 1'b1;
               @(posedge clk); #1;
               ack32 = 1'b0; ack64 = 1'b0;
            end
         end
         if (tmo) begin
            @(negedge clk);
            chk("bus_released", 64'({o_rd, o_wr}), 64'd0);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int g;
      rst32 = 1'b1; rst64 = 1'b1;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s[0]; #0;
         chk("rst_ready", 64'(o_rdy), 64'd0);
         chk("rst_en", 64'({o_rd, o_wr}), 64'd0);
         chk("rst_maddr", 64'(o_maddr), 64'd0);
         chk("rst_strb", 64'(o_strb), 64'd0);
         chk("rst_wdata", o_wd, 64'd0);
         chk("rst_busy", 64'(o_busy), 64'd0);
      end
      chk("rst_resp", 64'({rvld32, rvld64}), 64'd0);
      rst32 = 1'b0; rst64 = 1'b0; #1;
      chk("ready_after_rst", 64'({rdy32, rdy64}), 64'd3);

      // 32-bit unit
      issue(0, 0, 3'b010, 32'h1000_0004, 64'h0, 64'hDEAD_BEEF, 3, 0, 1,
            32'h1000_0004, 64'h0, 8'h0, 64'hDEAD_BEEF, 2'd0);
      issue(0, 0, 3'b000, 32'h1000_0003, 64'h0, 64'h80FF_1234, 0, 0, 1,
            32'h1000_0000, 64'h0, 8'h0, 64'hFFFF_FF80, 2'd0);
      issue(0, 0, 3'b100, 32'h1000_0003, 64'h0, 64'h80FF_1234, 1, 0, 1,
            32'h1000_0000, 64'h0, 8'h0, 64'h0000_0080, 2'd0);
      issue(0, 0, 3'b101, 32'h1000_0002, 64'h0, 64'h80FF_1234, 0, 0, 1,
            32'h1000_0000, 64'h0, 8'h0, 64'h0000_80FF, 2'd0);
      issue(0, 0, 3'b001, 32'h1000_0000, 64'h0, 64'h1234_8001, 0, 0, 1,
            32'h1000_0000, 64'h0, 8'h0, 64'hFFFF_8001, 2'd0);
      issue(0, 1, 3'b001, 32'h1000_0002, 64'h0000_ABCD, 64'hFFFF_FFFF, 0, 0, 1,
            32'h1000_0000, 64'hABCD_ABCD, 8'h0C, 64'h0, 2'd0);
      issue(0, 1, 3'b000, 32'h1000_0001, 64'h1234_565A, 64'h0, 2, 0, 1,
            32'h1000_0000, 64'h5A5A_5A5A, 8'h02, 64'h0, 2'd0);
      issue(0, 0, 3'b010, 32'h1000_0002, 64'h0, 64'h0, 0, 0, 0,
            32'h0, 64'h0, 8'h0, 64'h0, 2'd1);
      issue(0, 0, 3'b011, 32'h1000_0000, 64'h0, 64'h0, 0, 0, 0,
            32'h0, 64'h0, 8'h0, 64'h0, 2'd2);
      issue(0, 1, 3'b100, 32'h1000_0000, 64'h55, 64'h0, 0, 0, 0,
            32'h0, 64'h0, 8'h0, 64'h0, 2'd2);
      issue(0, 0, 3'b010, 32'h1000_0008, 64'h0, 64'h0, 7, 1, 1,
            32'h1000_0008, 64'h0, 8'h0, 64'h0, 2'd3);
      issue(0, 0, 3'b010, 32'h1000_0008, 64'h0, 64'h1234_5678, 7, 0, 1,
            32'h1000_0008, 64'h0, 8'h0, 64'h1234_5678, 2'd0);

      // 64-bit unit: abandon a store with reset, then normal traffic
      sel = 1'b1;
      @(negedge clk);
      st = 1'b1; f3 = 3'b010; addr = 32'h1000_0100; wdata = 64'h1111_2222; rv64 = 1'b1;
      @(posedge clk); #1;
      rv64 = 1'b0;
      @(negedge clk);
      chk("rst_mid_wr_before", 64'(wr64), 64'd1);
      #2 rst64 = 1'b1;
      #1;
      chk("rst_mid_wr_drop", 64'(wr64), 64'd0);
      chk("rst_mid_busy", 64'(busy64), 64'd0);
      chk("rst_mid_ready", 64'(rdy64), 64'd0);
      @(negedge clk);
      rst64 = 1'b0;
      issue(1, 0, 3'b010, 32'h1000_0004, 64'h0, 64'h8000_0001_0000_0000, 0, 0, 1,
            32'h1000_0000, 64'h0, 8'h0, 64'hFFFF_FFFF_8000_0001, 2'd0);
      issue(1, 0, 3'b011, 32'h1000_0008, 64'h0, 64'h0123_4567_89AB_CDEF, 2, 0, 1,
            32'h1000_0008, 64'h0, 8'h0, 64'h0123_4567_89AB_CDEF, 2'd0);
      issue(1, 1, 3'b010, 32'h1000_0004, 64'hCAFE_BABE, 64'h0, 0, 0, 1,
            32'h1000_0000, 64'hCAFE_BABE_CAFE_BABE, 8'hF0, 64'h0, 2'd0);
      issue(1, 0, 3'b110, 32'h1000_0000, 64'h0, 64'hFFFF_FFFF_F000_0000, 0, 0, 1,
            32'h1000_0000, 64'h0, 8'h0, 64'h0000_0000_F000_0000, 2'd0);
      issue(1, 0, 3'b011, 32'h1000_0004, 64'h0, 64'h0, 0, 0, 0,
            32'h0, 64'h0, 8'h0, 64'h0, 2'd1);

      g = 0;
      while ((q32.size() != 0 || q64.size() != 0) && g < 50) begin @(negedge clk); g++; end
      chk("pending_responses", 64'(q32.size() + q64.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rv_lsu_multicycle.md
Name: rv_lsu_multicycle

Overview:
- Parametrised load/store unit for the multicycle RV core family. Generalised in data width (XLEN 32/64).
- Adds behaviour the current word-only path lacks:
  - byte/half/word/dword accesses with sign/zero extension and byte write strobes;
  - variable-latency memory handshake (mem_ack);
  - misalignment and illegal-size detection;
  - bus timeout.
- Sits between the core FSM's memory-address stage and the system memory bus.

Parameters:
- XLEN, 32, data width in bits; legal values 32 or 64. BYTES = XLEN/8 is derived.
- ADDR_W, 32, address width in bits.
- TIMEOUT_CYCLES, 255, maximum wait for mem_ack; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  access request from the core FSM.
- req_ready  out  1  unit idle; request accepted when req_valid & req_ready.
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3. [1:0] = size (0 B, 1 H, 2 W, 3 D); [2] = unsigned (loads only).
- req_addr  in  ADDR_W  byte address (rs1 + imm).
- req_wdata  in  XLEN  store data (rs2), LSB-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_err  out  2  0 OK, 1 MISALIGNED, 2 ILLEGAL, 3 TIMEOUT.
- mem_addr  out  ADDR_W  BYTES-aligned bus address.
- mem_wr_data  out  XLEN  lane-replicated store data.
- mem_wr_strb  out  BYTES  byte-enable strobe.
- mem_rd_ena  out  1  read request, held until mem_ack.
- mem_wr_ena  out  1  write request, held until mem_ack.
- mem_ack  in  1  bus completion; read data valid in the same cycle.
- mem_rd_data  in  XLEN  bus read data.
- busy  out  1  state != S_IDLE.

Behaviour:
- Reset and clocking:
  - Asynchronous active-high reset; all flops are async-reset.
  - On rst: state = S_IDLE; resp_valid = 0; resp_rdata = 0; resp_err = 0; mem_rd_ena = 0; mem_wr_ena = 0; mem_wr_strb = 0; mem_addr = 0; mem_wr_data = 0; timeout counter = 0.
  - req_ready = (state == S_IDLE) & ~rst. It is 1 in the first cycle after rst deasserts.
- States: S_IDLE, S_ACCESS, S_RESP.
- S_IDLE, on accept, latches addr/size/unsigned/is_store/wdata and classifies the request:
  - size > log2(BYTES) → ILLEGAL. Example: size 3 when XLEN = 32.
  - store with funct3[2] = 1 → ILLEGAL.
  - addr not aligned to 2^size → MISALIGNED.
  - Any error → S_RESP with no bus activity.
  - Otherwise → S_ACCESS.
- S_ACCESS bus outputs:
  - mem_rd_ena or mem_wr_ena = 1, driven from state (deasserts asynchronously on rst).
  - mem_addr = addr with low log2(BYTES) bits cleared.
  - lane = addr[log2(BYTES)-1:0].
  - mem_wr_strb = ((1 << 2^size) - 1) << lane for stores; 0 for loads.
  - mem_wr_data = req_wdata low 2^size bytes replicated across all lanes.
- S_ACCESS exit conditions:
  - On mem_ack (sampled at the rising edge): load data = mem_rd_data >> (8·lane), truncated to the access size, then sign-extended (funct3[2] = 0) or zero-extended (funct3[2] = 1) to XLEN and registered; → S_RESP.
  - Timeout counter increments each S_ACCESS cycle without ack. When TIMEOUT_CYCLES ≠ 0 and the count reaches TIMEOUT_CYCLES → TIMEOUT, → S_RESP, enables drop.
  - mem_ack in the same cycle the count reaches TIMEOUT_CYCLES: ack wins.
- S_RESP:
  - resp_valid = 1 for exactly one cycle; resp_rdata and resp_err registered; → S_IDLE.
  - No back-pressure on responses.
- Latency:
  - With ack in the first S_ACCESS cycle: accept at edge N; bus enables in cycle N..N+1; resp_valid in cycle N+2..N+3. Total is 3 cycles accept-to-idle, plus one cycle per bus wait.
  - Error path: resp_valid in the cycle after accept.
- Ignored inputs:
  - mem_ack outside S_ACCESS is ignored.
  - req_valid outside S_IDLE is ignored (req_ready = 0).
- Reset mid-access: the transaction is abandoned with no resp_valid; the bus sees its enable fall immediately.

Decomposition:
- Shared package (rv_lsu_pkg, or added to rv32i_defines):
  - funct3 size/unsigned constants (FUNCT3_LB…FUNCT3_SD);
  - lsu_err_t enum {LSU_OK, LSU_MISALIGNED, LSU_ILLEGAL, LSU_TIMEOUT};
  - lsu_state_t enum.
- One combinational sub-module, lsu_load_align: lane shift, size truncation and sign/zero extension, parametrised on XLEN. It is reused by a future pipelined core.

Test Plan:
- LW, XLEN = 32, addr 0x10000004, ack after 3 wait cycles, rd_data 0xDEADBEEF → mem_addr 0x10000004; resp_rdata 0xDEADBEEF; resp_err 0; resp_valid 1 cycle after ack; 6 cycles accept-to-idle.
- LB at addr 0x10000003, rd_data 0x80FF1234 → resp_rdata 0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x10000002 → 0x000080FF.
- SH at addr 0x10000002, wdata 0x0000ABCD → mem_addr 0x10000000; mem_wr_data 0xABCDABCD; mem_wr_strb 4'b1100; resp_err 0.
- Error requests → no mem enable; resp_valid in the next cycle:
  - LW at 0x10000002 → resp_err 1.
  - funct3 3'b011 (LD) with XLEN = 32 → resp_err 2.
  - store funct3 3'b100 → resp_err 2.
- TIMEOUT_CYCLES = 8, mem_ack held 0 → mem_rd_ena high exactly 8 cycles, then low; resp_err 3; req_ready 1 in the following cycle. Also: ack and timeout coincide → resp_err 0.
- rst pulsed mid-S_ACCESS → mem_wr_ena falls before the next clock edge; no resp_valid. XLEN = 64 LW at 0x…0004, rd_data 0x8000000100000000 → resp_rdata 0xFFFFFFFF80000001. A subsequent request completes normally.
